// File: rtl/cabac_encoder.sv
// cabac_encoder: binary arithmetic encoder engine (regular/bypass bins, flush).
// 9-bit range, 10-bit low, one renormalisation shift per cycle, serial output,
// outstanding-bit resolution with a saturating counter.
// Optional feature: define CABAC_ENC_BIN_COUNT_EN to add the bin_count output.
module cabac_encoder #(
  parameter int OUTSTANDING_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bin_valid,
  output logic       bin_ready,
  input  logic       bin_val,
  input  logic       bypass,
  input  logic [7:0] pState_in,
  input  logic       flush,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       done,
  output logic       ovf_err
`ifdef CABAC_ENC_BIN_COUNT_EN
  ,
  output logic [15:0] bin_count
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RENORM   = 3'd1;
  localparam logic [2:0] S_EMIT     = 3'd2;
  localparam logic [2:0] S_FL_PUT   = 3'd3;
  localparam logic [2:0] S_FL_TAIL0 = 3'd4;
  localparam logic [2:0] S_FL_TAIL1 = 3'd5;

  localparam logic [OUTSTANDING_W-1:0] OUT_ZERO = {OUTSTANDING_W{1'b0}};
  localparam logic [OUTSTANDING_W-1:0] OUT_MAX  = {OUTSTANDING_W{1'b1}};
  localparam logic [OUTSTANDING_W-1:0] OUT_ONE  = {{(OUTSTANDING_W-1){1'b0}}, 1'b1};

  // LPS sub-range, bit-exact with the decoder: (((range>>5)*q)>>3)+4
  function automatic logic [8:0] calc_rlps(input logic [8:0] rng, input logic [6:0] q);
    logic [10:0] prod;
    prod = {7'd0, rng[8:5]} * {4'd0, q};
    return {1'b0, prod[10:3]} + 9'd4;
  endfunction

  logic [2:0]               state_q, state_d, ret_q, ret_d;
  logic [9:0]               low_q, low_d;
  logic [8:0]               range_q, range_d;
  logic [OUTSTANDING_W-1:0] outstanding_q, outstanding_d;
  logic                     first_bit_q, first_bit_d;
  logic                     flushing_q, flushing_d;
  logic                     put_q, put_d;
  logic                     bit_valid_q, bit_valid_d;
  logic                     bit_out_q, bit_out_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     bin_ready_q, bin_ready_d;

  logic                     put_req_s, put_b_s, inc_out_s;
  logic [2:0]               put_ret_s, renorm_next_s;
  logic [10:0]              ext_s;
  logic [8:0]               rlps_s, rng_tmp_s;
  logic [9:0]               low_tmp_s;

  // Next-state: bin/flush acceptance, renorm step, PutBit and serial emission
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    low_d         = low_q;
    range_d       = range_q;
    outstanding_d = outstanding_q;
    first_bit_d   = first_bit_q;
    flushing_d    = flushing_q;
    put_d         = put_q;
    bit_valid_d   = 1'b0;
    bit_out_d     = 1'b0;
    done_d        = 1'b0;
    ovf_d         = ovf_q;
    put_req_s     = 1'b0;
    put_b_s       = 1'b0;
    put_ret_s     = S_IDLE;
    inc_out_s     = 1'b0;
    ext_s         = 11'd0;
    rlps_s        = 9'd0;
    rng_tmp_s     = 9'd0;
    low_tmp_s     = 10'd0;
    renorm_next_s = S_RENORM;

    case (state_q)
      S_IDLE: begin
        if (bin_valid) begin
          if (bypass) begin
            ext_s = {low_q, 1'b0} + (bin_val ? {2'b00, range_q} : 11'd0);
            put_ret_s = S_IDLE;
            state_d   = S_IDLE;
            if (ext_s >= 11'd1024) begin
              put_req_s = 1'b1;
              put_b_s   = 1'b1;
              low_d     = ext_s[9:0];
            end else if (ext_s < 11'd512) begin
              put_req_s = 1'b1;
              put_b_s   = 1'b0;
              low_d     = ext_s[9:0];
            end else begin
              low_d     = ext_s[9:0] - 10'd512;
              inc_out_s = 1'b1;
            end
          end else begin
            rlps_s = calc_rlps(range_q, pState_in[6:0]);
            if (bin_val == pState_in[7]) begin
              rng_tmp_s = range_q - rlps_s;
            end else begin
              low_d     = low_q + {1'b0, range_q - rlps_s};
              rng_tmp_s = rlps_s;
            end
            range_d = rng_tmp_s;
            if (rng_tmp_s < 9'd256) begin
              state_d = S_RENORM;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (flush) begin
          rng_tmp_s  = range_q - 9'd2;
          low_d      = low_q + {1'b0, rng_tmp_s};
          range_d    = 9'd2;
          flushing_d = 1'b1;
          state_d    = S_RENORM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RENORM: begin
        if (low_q < 10'd256) begin
          low_tmp_s = low_q;
          put_req_s = 1'b1;
          put_b_s   = 1'b0;
        end else if (low_q >= 10'd512) begin
          low_tmp_s = low_q - 10'd512;
          put_req_s = 1'b1;
          put_b_s   = 1'b1;
        end else begin
          low_tmp_s = low_q - 10'd256;
          inc_out_s = 1'b1;
        end
        low_d   = low_tmp_s << 1;
        range_d = range_q << 1;
        // After this shift the interval is normalised once range bit 7 moves up
        if (range_q[7]) begin
          renorm_next_s = flushing_q ? S_FL_PUT : S_IDLE;
        end else begin
          renorm_next_s = S_RENORM;
        end
        put_ret_s = renorm_next_s;
        state_d   = renorm_next_s;
      end
      S_EMIT: begin
        if (outstanding_q != OUT_ZERO) begin
          bit_valid_d   = 1'b1;
          bit_out_d     = ~put_q;
          outstanding_d = outstanding_q - OUT_ONE;
        end else begin
          state_d = ret_q;
        end
      end
      S_FL_PUT: begin
        put_req_s = 1'b1;
        put_b_s   = low_q[9];
        put_ret_s = S_FL_TAIL0;
        state_d   = S_FL_TAIL0;
      end
      S_FL_TAIL0: begin
        bit_valid_d = 1'b1;
        bit_out_d   = low_q[8];
        state_d     = S_FL_TAIL1;
      end
      S_FL_TAIL1: begin
        bit_valid_d   = 1'b1;
        bit_out_d     = 1'b1;
        done_d        = 1'b1;
        low_d         = 10'd0;
        range_d       = 9'd510;
        outstanding_d = OUT_ZERO;
        first_bit_d   = 1'b1;
        flushing_d    = 1'b0;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Deferred-carry bookkeeping: counter saturates and flags the overflow
    if (inc_out_s) begin
      if (outstanding_q == OUT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q + OUT_ONE;
      end
    end else begin
      ovf_d = ovf_q;
    end

    // PutBit: the very first bit of a slice is suppressed, then outstanding
    // bits of opposite polarity drain one per cycle in EMIT
    if (put_req_s) begin
      first_bit_d = 1'b0;
      put_d       = put_b_s;
      ret_d       = put_ret_s;
      if (!first_bit_q) begin
        bit_valid_d = 1'b1;
        bit_out_d   = put_b_s;
        state_d     = S_EMIT;
      end else if (outstanding_q != OUT_ZERO) begin
        bit_valid_d   = 1'b1;
        bit_out_d     = ~put_b_s;
        outstanding_d = outstanding_q - OUT_ONE;
        state_d       = S_EMIT;
      end else begin
        state_d = put_ret_s;
      end
    end else begin
      put_d = put_q;
    end

    bin_ready_d = (state_d == S_IDLE);
  end

  // Engine state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ret_q         <= S_IDLE;
      low_q         <= 10'd0;
      range_q       <= 9'd510;
      outstanding_q <= OUT_ZERO;
      first_bit_q   <= 1'b1;
      flushing_q    <= 1'b0;
      put_q         <= 1'b0;
      bit_valid_q   <= 1'b0;
      bit_out_q     <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      bin_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      low_q         <= low_d;
      range_q       <= range_d;
      outstanding_q <= outstanding_d;
      first_bit_q   <= first_bit_d;
      flushing_q    <= flushing_d;
      put_q         <= put_d;
      bit_valid_q   <= bit_valid_d;
      bit_out_q     <= bit_out_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
      bin_ready_q   <= bin_ready_d;
    end
  end

  assign bin_ready = bin_ready_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign done      = done_q;
  assign ovf_err   = ovf_q;

`ifdef CABAC_ENC_BIN_COUNT_EN
  logic [15:0] bin_count_q, bin_count_d;

  // Accepted-bin counter, wraps naturally, cleared together with done
  always_comb begin
    if (done_d) begin
      bin_count_d = 16'd0;
    end else if ((state_q == S_IDLE) && bin_valid) begin
      bin_count_d = bin_count_q + 16'd1;
    end else begin
      bin_count_d = bin_count_q;
    end
  end

  // Bin counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_count_q <= 16'd0;
    end else begin
      bin_count_q <= bin_count_d;
    end
  end

  assign bin_count = bin_count_q;
`else
  // Bin counter not built in this configuration.
`endif

endmodule

// File: doc/cabac_encoder.md
# cabac_encoder

Binary arithmetic encoder engine for the VVC CABAC path, the transmit-side counterpart of the bin decoder. It accepts regular and bypass bins one at a time over a valid/ready handshake, and maintains the 9-bit range and 10-bit low registers. It renormalises one shift per cycle, resolves outstanding bits, and emits the bitstream serially, one bit per cycle. Its range/LPS arithmetic is bit-exact with the decoder's, so any stream it produces decodes back to the same bins.

## Interface
- `OUTSTANDING_W`, default 8: width of the outstanding-bit counter.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `bin_valid` in 1: a bin is offered.
- `bin_ready` out 1: the engine can accept a bin (high only in IDLE).
- `bin_val` in 1: bin value.
- `bypass` in 1: 1 = equiprobable bypass bin; 0 = regular bin.
- `pState_in` in 8: bit[7] = valMps; bits[6:0] = q, the LPS probability. Ignored when `bypass`=1.
- `flush` in 1: terminate the slice. Accepted only in IDLE when `bin_valid`=0. Has priority over nothing; `bin_valid` wins if both are high.
- `bit_valid` out 1: `bit_out` is valid this cycle. No backpressure.
- `bit_out` out 1: bitstream bit, MSB-first stream order.
- `done` out 1: one-cycle pulse when the flush tail bit has been emitted.
- `ovf_err` out 1: sticky; set when the outstanding counter would exceed 2^OUTSTANDING_W−1. Cleared only by reset.

## Operation
- Registers and their reset/init values:
  - `low[9:0]` = 0
  - `range[8:0]` = 510
  - `outstanding` = 0
  - `first_bit` = 1
  - state = IDLE
- All outputs are 0 at reset, except `bin_ready`=1.
- States: IDLE, RENORM, EMIT, FL_PUT, FL_TAIL0, FL_TAIL1.
- rLPS = (((range>>5) × q) >> 3) + 4.
  - Intermediate is 11 bits; the result is 9 bits.
- Regular bin, applied at the acceptance edge:
  - MPS (`bin_val`==valMps): range −= rLPS.
  - LPS: low += range − rLPS; range = rLPS.
  - Next state is RENORM if range<256, else IDLE.
- RENORM, one iteration per cycle:
  - If low<256: PutBit(0).
  - Else if low≥512: low −= 512, then PutBit(1).
  - Else: low −= 256 and outstanding++.
  - Then range<<=1 and low<<=1 (10-bit, carry discarded).
  - Loop until range≥256.
- Bypass bin, applied at the acceptance edge:
  - low = (low<<1) + (`bin_val` ? range : 0), with an 11-bit intermediate.
  - If result ≥1024: PutBit(1), low −= 1024.
  - Else if result <512: PutBit(0).
  - Else: low −= 512, outstanding++.
- PutBit(b):
  - If `first_bit`=1: clear it and emit nothing.
  - Otherwise emit b.
  - Then emit !b `outstanding` times, clearing the counter.
  - Each emitted bit costs one cycle in EMIT. The return state (RENORM/IDLE/FL_TAIL0) is saved.
- Flush sequence:
  - range −= 2; low += range; range = 2.
  - RENORM (7 iterations).
  - FL_PUT: PutBit(low[9]).
  - FL_TAIL0: emit low[8].
  - FL_TAIL1: emit 1 and pulse `done`.
  - Then re-initialise low, range, `first_bit`, and `outstanding` to their reset values, and go to IDLE.
- Outstanding saturation: if the counter is at its maximum, it is held and `ovf_err` is set. The emitted stream is then undefined.
- Reset asserted mid-operation: all state clears immediately; any partially emitted bits are discarded.

## Timing
- Bin accepted on edge N:
  - Without renorm or PutBit, `bin_ready` is high again from N+1.
  - With k renorm shifts and no bits emitted, `bin_ready` is high from N+1+k.
  - Each emitted bit adds one cycle.
- `bit_valid` is registered, at most one bit per cycle.
  - The first bit of a PutBit appears in the cycle after the decision.
  - Outstanding bits follow on consecutive cycles with no gaps.
- `flush` accepted on edge N:
  - 7 RENORM cycles, then FL_PUT and its EMIT cycles, then FL_TAIL0 and FL_TAIL1.
  - `done` is high in the same cycle as the final `bit_valid` (value 1).
- `bin_ready` is low in every non-IDLE state. `flush` outside IDLE is ignored.

## Configuration
- `CABAC_ENC_BIN_COUNT_EN`:
  - Defined: adds output `bin_count` [15:0].
    - Increments on each accepted bin and wraps at 65535→0.
    - Clears on reset and in the cycle `done` pulses.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset, then bypass 1 → `first_bit` cleared, low=510, no `bit_valid`. Bypass 1 again → single `bit_out`=1 on the next cycle, low=506.
- Reset, then regular bin 0 with `pState_in`=0x00 → rLPS=4, range=506, no output, `bin_ready` high on the next cycle.
- Reset, then regular bin 1 with `pState_in`=0x7F (LPS):
  - rLPS=242, low=268, range=242.
  - 1 RENORM cycle → outstanding=1, low=24, range=484.
  - `bin_ready` returns after 2 cycles, no bits emitted.
- Build outstanding=3 (with `first_bit` cleared), then trigger PutBit(1) → `bit_out` sequence 1,0,0,0 on 4 consecutive cycles, `bin_ready` low throughout.
- Encode 16 random bins, then `flush`:
  - The decoder model reproduces all bins.
  - The last two emitted bits are low[8] and 1; `done` coincides with the final bit.
  - Engine state returns to low=0, range=510.
- Assert `reset_n` low during EMIT → `bit_valid` drops immediately, `bin_ready`=1 after release, `ovf_err`=0.
